// File: rtl/shift_arbiter_ctrl_pkg.sv
// Shared types and constants for the shift arbiter/sequencer.
package shift_arbiter_ctrl_pkg;

  localparam int unsigned WIDTH_DEF = 6;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

  // One-hot request/grant vector for a port index.
  function automatic logic [1:0] port_onehot(input logic port);
    return (port == PORT1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/shift_right_core.sv
// Combinational logical right shift; amounts of W or more yield zero.
module shift_right_core #(
  parameter int unsigned W = 6
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] s
);

  always_comb begin
    s = '0;
    if (32'(b) < W) s = a >> b;
  end

endmodule

// File: rtl/shift_arbiter_ctrl.sv
// Round-robin sequencer for two requesters sharing one right-shift datapath.
module shift_arbiter_ctrl
  import shift_arbiter_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter int unsigned RR_INIT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic [1:0]       ack,
  output logic [1:0]       gnt,
  output logic [WIDTH-1:0] res,
  output logic [1:0]       res_valid,
  output logic             busy
);

  state_t           state, state_nxt;
  logic             ptr, ptr_nxt;
  logic             win, win_nxt;
  logic [WIDTH-1:0] a_q, a_nxt, b_q, b_nxt;
  logic [WIDTH-1:0] res_nxt, shift_s;
  logic [1:0]       gnt_nxt, res_valid_nxt;
  logic             busy_nxt;
  logic             sel;

  shift_right_core #(.W(WIDTH)) u_core (
    .a (a_q),
    .b (b_q),
    .s (shift_s)
  );

  // Lone requester wins outright; on contention the pointer decides.
  assign sel = (req[0] && req[1]) ? ptr : (req[1] ? PORT1 : PORT0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 1'(RR_INIT);
      win       <= PORT0;
      a_q       <= '0;
      b_q       <= '0;
      gnt       <= '0;
      res       <= '0;
      res_valid <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      win       <= win_nxt;
      a_q       <= a_nxt;
      b_q       <= b_nxt;
      gnt       <= gnt_nxt;
      res       <= res_nxt;
      res_valid <= res_valid_nxt;
      busy      <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    win_nxt       = win;
    a_nxt         = a_q;
    b_nxt         = b_q;
    gnt_nxt       = '0;
    res_nxt       = res;
    res_valid_nxt = res_valid;
    case (state)
      IDLE: begin
        if (|req) begin
          win_nxt   = sel;
          a_nxt     = (sel == PORT1) ? a1 : a0;
          b_nxt     = (sel == PORT1) ? b1 : b0;
          gnt_nxt   = port_onehot(sel);
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        res_nxt       = shift_s;
        res_valid_nxt = port_onehot(win);
        state_nxt     = RESP;
      end
      RESP: begin
        // Pointer moves only on completion, away from the port just served.
        if (ack[win]) begin
          res_valid_nxt = '0;
          ptr_nxt       = ~win;
          state_nxt     = IDLE;
        end
      end
      default: begin
        res_valid_nxt = '0;
        state_nxt     = IDLE;
      end
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_shift_arbiter_ctrl.sv
// Self-checking bench: vector table, directed corner sequences, randomized traffic vs. a transaction model.
module tb_shift_arbiter_ctrl;

  localparam int unsigned W = 6;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req, ack, gnt, res_valid;
  logic [W-1:0] a0, b0, a1, b1, res;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  shift_arbiter_ctrl #(.WIDTH(W), .RR_INIT(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .a0        (a0),
    .b0        (b0),
    .a1        (a1),
    .b1        (b1),
    .ack       (ack),
    .gnt       (gnt),
    .res       (res),
    .res_valid (res_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   req;
    logic [W-1:0] a0, b0, a1, b1;
    logic [1:0]   exp_gnt;
    logic [W-1:0] exp_res;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; ack = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Reference shift: integer division by a power of two, zero once the amount reaches the width.
  function automatic int unsigned ref_shift(input int unsigned a, input int unsigned b);
    if (b >= W) return 0;
    return a / (32'd1 << b);
  endfunction

  function automatic logic [1:0] onehot(input int unsigned p);
    return (p == 1) ? 2'b10 : 2'b01;
  endfunction

  logic [1:0]   gq[$];
  logic [W-1:0] held;
  int unsigned  ptr_m, win_m, exp_r, d;
  logic [1:0]   r;

  initial begin
    rst = 1'b1; req = '0; ack = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;

    // Pointer evolution (RR_INIT=0) worked out entry by entry.
    vecs[0] = '{2'b01, 6'b101101, 6'd2,  6'd0,     6'd0,  2'b01, 6'b001011};
    vecs[1] = '{2'b10, 6'd0,      6'd0,  6'b111111, 6'd6, 2'b10, 6'd0};
    vecs[2] = '{2'b10, 6'd0,      6'd0,  6'b111111, 6'd63, 2'b10, 6'd0};
    vecs[3] = '{2'b01, 6'd48,     6'd0,  6'd7,     6'd1,  2'b01, 6'd48};
    vecs[4] = '{2'b11, 6'd5,      6'd1,  6'd40,    6'd3,  2'b10, 6'd5};
    vecs[5] = '{2'b11, 6'd63,     6'd5,  6'd1,     6'd0,  2'b01, 6'd1};
    vecs[6] = '{2'b01, 6'b100000, 6'd5,  6'd0,     6'd0,  2'b01, 6'd1};

    tick(); tick();
    chk("reset_gnt", gnt, 0);
    chk("reset_res_valid", res_valid, 0);
    chk("reset_res", res, 0);
    chk("reset_busy", busy, 0);
    rst = 1'b0;

    // Table vectors, ack tied high.
    ack = 2'b11;
    for (int i = 0; i < 7; i++) begin
      req = vecs[i].req; a0 = vecs[i].a0; b0 = vecs[i].b0; a1 = vecs[i].a1; b1 = vecs[i].b1;
      tick();
      chk($sformatf("vec%0d_gnt", i), gnt, vecs[i].exp_gnt);
      chk($sformatf("vec%0d_busy", i), busy, 1);
      req = '0;
      tick();
      chk($sformatf("vec%0d_gnt_pulse", i), gnt, 0);
      chk($sformatf("vec%0d_valid", i), res_valid, vecs[i].exp_gnt);
      chk($sformatf("vec%0d_res", i), res, vecs[i].exp_res);
      tick();
      chk($sformatf("vec%0d_valid_drop", i), res_valid, 0);
      chk($sformatf("vec%0d_idle", i), busy, 0);
    end

    // Continuous contention alternates grants starting at port 0.
    do_reset();
    req = 2'b11; ack = 2'b11;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (gnt != 2'b00) gq.push_back(gnt);
    end
    req = '0;
    chk("contend_count_ge4", (gq.size() >= 4) ? 1 : 0, 1);
    for (int k = 0; k < 4 && k < gq.size(); k++)
      chk($sformatf("contend_gnt%0d", k), gq[k], onehot(k % 2));
    tick(); tick(); tick();

    // Delayed ack: result held, foreign ack ignored.
    do_reset();
    ack = 2'b00; req = 2'b01; a0 = 6'd44; b0 = 6'd1;
    tick();
    chk("dly_gnt", gnt, 2'b01);
    req = '0;
    tick();
    chk("dly_valid", res_valid, 2'b01);
    chk("dly_res", res, 22);
    ack = 2'b10;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("dly_hold_valid%0d", c), res_valid, 2'b01);
      chk($sformatf("dly_hold_res%0d", c), res, 22);
    end
    ack = 2'b01;
    tick();
    chk("dly_done_valid", res_valid, 0);
    chk("dly_done_busy", busy, 0);

    // Operands change after grant: captured value must be used.
    req = 2'b01; a0 = 6'b100000; b0 = 6'd5;
    tick();
    chk("cap_gnt", gnt, 2'b01);
    req = '0; a0 = 6'b000001;
    tick();
    chk("cap_res", res, 1);
    tick();

    // Reset mid-operation with pointer away from RR_INIT.
    req = 2'b01; a0 = 6'd63; b0 = 6'd0; ack = 2'b01;
    tick(); req = '0; tick(); tick();
    chk("rstmid_prev_res", res, 63);
    req = 2'b01; ack = 2'b00;
    tick();
    chk("rstmid_gnt", gnt, 2'b01);
    rst = 1'b1; req = '0;
    tick();
    chk("rstmid_gnt0", gnt, 0);
    chk("rstmid_valid0", res_valid, 0);
    chk("rstmid_res0", res, 0);
    chk("rstmid_busy0", busy, 0);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("rstmid_novalid%0d", c), res_valid, 0);
    end
    req = 2'b11; ack = 2'b11;
    tick();
    chk("rstmid_ptr_init", gnt, 2'b01);
    req = '0;
    tick(); tick();

    // Randomized traffic against the transaction-level model.
    do_reset();
    ptr_m = 0;
    for (int t = 0; t < 150; t++) begin
      r = 2'($urandom_range(1, 3));
      req = r; ack = '0;
      a0 = 6'($urandom_range(0, 63)); a1 = 6'($urandom_range(0, 63));
      b0 = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63));
      b1 = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63));
      win_m = (r == 2'b11) ? ptr_m : ((r == 2'b10) ? 1 : 0);
      exp_r = (win_m == 1) ? ref_shift(a1, b1) : ref_shift(a0, b0);
      tick();
      chk("rnd_gnt", gnt, onehot(win_m));
      req = '0;
      a0 = 6'($urandom); b0 = 6'($urandom); a1 = 6'($urandom); b1 = 6'($urandom);
      tick();
      chk("rnd_valid", res_valid, onehot(win_m));
      chk("rnd_res", res, exp_r);
      held = res;
      d = $urandom_range(0, 3);
      ack = ($urandom_range(0, 1) != 0) ? onehot(1 - win_m) : 2'b00;
      for (int c = 0; c < int'(d); c++) begin
        tick();
        chk("rnd_hold_valid", res_valid, onehot(win_m));
        chk("rnd_hold_res", res, held);
      end
      ack = onehot(win_m) | (($urandom_range(0, 1) != 0) ? onehot(1 - win_m) : 2'b00);
      tick();
      chk("rnd_done_valid", res_valid, 0);
      chk("rnd_done_busy", busy, 0);
      ack = '0;
      ptr_m = 1 - win_m;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
